// File: rtl/relay_pkg.sv
// Shared types and helpers for the relay contact models: contact FSM states and
// the 16-bit Galois LFSR used to generate contact chatter.
package relay_pkg;

    typedef enum logic [1:0] {
        OPEN         = 2'd0,
        BOUNCE_MAKE  = 2'd1,
        CLOSED       = 2'd2,
        BOUNCE_BREAK = 2'd3
    } contact_state_t;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One right-shifting Galois step; the tap mask is folded in when bit 0 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Bit 0 of the state that lfsr_step would produce, without building the whole word.
    function automatic logic lfsr_next_lsb(input logic [15:0] s);
        lfsr_next_lsb = s[1] ^ (s[0] & LFSR_MASK[0]);
    endfunction

endpackage

// File: rtl/relay_contact_bounce_if.sv
// Contact bus between the relay side (tick, ideal contact) and the form-C
// contact outputs with their settle pulses.
interface relay_contact_bounce_if;
    logic tick;
    logic c;
    logic no;
    logic nc;
    logic stable;
    logic make_p;
    logic break_p;

    modport master (
        output tick, c,
        input  no, nc, stable, make_p, break_p
    );

    modport slave (
        input  tick, c,
        output no, nc, stable, make_p, break_p
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps on adv and reloads its seed on reset.
// Generic enough to drive any electromechanical chatter model.
module lfsr16
    import relay_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // State register: seed on reset, one Galois step per adv strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (adv) begin
            q <= lfsr_step(q);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/relay_contact_bounce.sv
// Form-C contact model: turns the relay's ideal contact into NO/NC outputs that
// chatter for a set number of ticks after each make or break, then settle.
module relay_contact_bounce
    import relay_pkg::*;
#(
    parameter int unsigned TB_MAKE   = 32'd4,
    parameter int unsigned TB_BREAK  = 32'd2,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED,
    parameter bit          BOUNCE_EN = 1'b1
)(
    input  logic                   clk,
    input  logic                   rst,
    relay_contact_bounce_if.slave  bus
);

    localparam int unsigned TB_MAX = (TB_MAKE > TB_BREAK) ? TB_MAKE : TB_BREAK;
    localparam int          CW     = (TB_MAX == 32'd0) ? 1 : $clog2(TB_MAX + 32'd1);

    localparam logic [CW-1:0] CTR_MAKE  = CW'(TB_MAKE);
    localparam logic [CW-1:0] CTR_BREAK = CW'(TB_BREAK);
    localparam logic [CW-1:0] CTR_ONE   = CW'(1);
    localparam logic [CW-1:0] CTR_ZERO  = CW'(0);

    // An all-zero seed would lock the LFSR, so substitute a live one.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    localparam bit MAKE_BOUNCES  = (BOUNCE_EN != 1'b0) && (TB_MAKE  != 32'd0);
    localparam bit BREAK_BOUNCES = (BOUNCE_EN != 1'b0) && (TB_BREAK != 32'd0);

    contact_state_t r_state;
    logic [CW-1:0]  r_ctr;
    logic           r_no;
    logic           r_nc;
    logic           r_stable;
    logic           r_make_p;
    logic           r_break_p;

    logic [15:0]    w_lfsr_q;
    logic           w_bouncing;
    logic           w_adv;
    logic           w_chatter;

    assign w_bouncing = (r_state == BOUNCE_MAKE) || (r_state == BOUNCE_BREAK);
    assign w_adv      = bus.tick && w_bouncing;
    assign w_chatter  = lfsr_next_lsb(w_lfsr_q);

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (w_adv),
        .seed (SEED_EFF),
        .q    (w_lfsr_q)
    );

    // Contact FSM with registered outputs; a reversal of c outranks a same-cycle tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= OPEN;
            r_ctr     <= CTR_ZERO;
            r_no      <= 1'b0;
            r_nc      <= 1'b1;
            r_stable  <= 1'b1;
            r_make_p  <= 1'b0;
            r_break_p <= 1'b0;
        end else begin
            r_make_p  <= 1'b0;
            r_break_p <= 1'b0;
            case (r_state)
                OPEN: begin
                    if (bus.c && MAKE_BOUNCES) begin
                        r_state  <= BOUNCE_MAKE;
                        r_ctr    <= CTR_MAKE;
                        r_no     <= 1'b0;
                        r_nc     <= 1'b0;
                        r_stable <= 1'b0;
                    end else if (bus.c) begin
                        r_state  <= CLOSED;
                        r_no     <= 1'b1;
                        r_nc     <= 1'b0;
                        r_stable <= 1'b1;
                        r_make_p <= 1'b1;
                    end else begin
                        r_no     <= 1'b0;
                        r_nc     <= 1'b1;
                        r_stable <= 1'b1;
                    end
                end
                BOUNCE_MAKE: begin
                    if (!bus.c && BREAK_BOUNCES) begin
                        r_state  <= BOUNCE_BREAK;
                        r_ctr    <= CTR_BREAK;
                        r_no     <= 1'b0;
                        r_nc     <= 1'b0;
                        r_stable <= 1'b0;
                    end else if (!bus.c) begin
                        r_state   <= OPEN;
                        r_ctr     <= CTR_ZERO;
                        r_no      <= 1'b0;
                        r_nc      <= 1'b1;
                        r_stable  <= 1'b1;
                        r_break_p <= 1'b1;
                    end else if (bus.tick && (r_ctr == CTR_ONE)) begin
                        r_state  <= CLOSED;
                        r_ctr    <= CTR_ZERO;
                        r_no     <= 1'b1;
                        r_stable <= 1'b1;
                        r_make_p <= 1'b1;
                    end else if (bus.tick) begin
                        r_ctr <= r_ctr - CTR_ONE;
                        r_no  <= w_chatter;
                    end else begin
                        r_ctr <= r_ctr;
                    end
                end
                CLOSED: begin
                    if (!bus.c && BREAK_BOUNCES) begin
                        r_state  <= BOUNCE_BREAK;
                        r_ctr    <= CTR_BREAK;
                        r_no     <= 1'b0;
                        r_nc     <= 1'b0;
                        r_stable <= 1'b0;
                    end else if (!bus.c) begin
                        r_state   <= OPEN;
                        r_no      <= 1'b0;
                        r_nc      <= 1'b1;
                        r_stable  <= 1'b1;
                        r_break_p <= 1'b1;
                    end else begin
                        r_no     <= 1'b1;
                        r_nc     <= 1'b0;
                        r_stable <= 1'b1;
                    end
                end
                BOUNCE_BREAK: begin
                    if (bus.c && MAKE_BOUNCES) begin
                        r_state  <= BOUNCE_MAKE;
                        r_ctr    <= CTR_MAKE;
                        r_no     <= 1'b0;
                        r_nc     <= 1'b0;
                        r_stable <= 1'b0;
                    end else if (bus.c) begin
                        r_state  <= CLOSED;
                        r_ctr    <= CTR_ZERO;
                        r_no     <= 1'b1;
                        r_nc     <= 1'b0;
                        r_stable <= 1'b1;
                        r_make_p <= 1'b1;
                    end else if (bus.tick && (r_ctr == CTR_ONE)) begin
                        r_state   <= OPEN;
                        r_ctr     <= CTR_ZERO;
                        r_nc      <= 1'b1;
                        r_stable  <= 1'b1;
                        r_break_p <= 1'b1;
                    end else if (bus.tick) begin
                        r_ctr <= r_ctr - CTR_ONE;
                        r_nc  <= w_chatter;
                    end else begin
                        r_ctr <= r_ctr;
                    end
                end
                default: begin
                    r_state  <= OPEN;
                    r_ctr    <= CTR_ZERO;
                    r_no     <= 1'b0;
                    r_nc     <= 1'b1;
                    r_stable <= 1'b1;
                end
            endcase
        end
    end

    assign bus.no      = r_no;
    assign bus.nc      = r_nc;
    assign bus.stable  = r_stable;
    assign bus.make_p  = r_make_p;
    assign bus.break_p = r_break_p;

endmodule
